// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-side types for the 5-stage RISC-V pipeline.
// Holds the IF/ID bundle and reservation-queue entry layout.
package if_fetch_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } IF_ID_t;

  typedef struct packed {
    logic  filled;
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  function automatic IF_ID_t if_id_bubble();
    IF_ID_t b;
    b.instr = NOP_INSTR;
    b.pc    = '0;
    return b;
  endfunction

endpackage

// File: rtl/if_fetch_stage_rsv_queue.sv
// Circular reservation queue for in-order instruction fetches.
// Entries are allocated at issue and filled oldest-first on response.
module fetch_rsv_queue
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_alloc,
  input  word_t        i_alloc_pc,
  input  logic         i_fill,
  input  word_t        i_fill_instr,
  input  logic         i_pop,
  output logic [CW-1:0] o_cnt,
  output fetch_entry_t o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_fptr;
  logic [CW-1:0] r_cnt;
  fetch_entry_t  r_ent [DEPTH];

  // Pointer, occupancy and entry storage updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_fptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (i_clear) begin
      r_head <= '0;
      r_tail <= '0;
      r_fptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].filled <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_ent[r_tail] <= '{filled: 1'b0,
                           instr: '0,
                           pc: i_alloc_pc};
        r_tail <= r_tail + PW'(1);
      end
      if (i_fill) begin
        r_ent[r_fptr].filled <= 1'b1;
        r_ent[r_fptr].instr  <= i_fill_instr;
        r_fptr <= r_fptr + PW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_cnt <= r_cnt + CW'(i_alloc) - CW'(i_pop);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_head = r_ent[r_head];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests,
// buffers responses and drives the IF/ID register with redirect/stall.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output IF_ID_t      if_id,
  output logic        if_id_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);

  word_t         r_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  IF_ID_t        r_if_id;
  logic          r_valid;

  logic [CW-1:0] w_q_cnt;
  fetch_entry_t  w_head;
  logic [CW:0]   w_space;
  logic          w_req;
  logic          w_acc;
  logic          w_rv;
  logic          w_drop;
  logic          w_fill;
  logic          w_pop;
  logic          w_unused;

  assign w_space = {1'b0, w_q_cnt} + {1'b0, r_drop_cnt};
  assign w_req   = rst_n && !redirect_valid
                && ({1'b0, w_q_cnt} < LIM)
                && (w_space < LIM);
  assign w_acc   = w_req && imem_ready;
  assign w_rv    = imem_rvalid && (r_out_cnt != '0);
  assign w_drop  = w_rv && (r_drop_cnt != '0);
  assign w_fill  = w_rv && !w_drop && !redirect_valid;
  assign w_pop   = !redirect_valid && !stall
                && w_head.filled && (w_q_cnt != '0);
  assign w_unused = ^redirect_pc[1:0];

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign if_id       = r_if_id;
  assign if_id_valid = r_valid;

  fetch_rsv_queue #(
    .DEPTH(DEPTH)
  ) u_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (redirect_valid),
    .i_alloc     (w_acc),
    .i_alloc_pc  (r_pc),
    .i_fill      (w_fill),
    .i_fill_instr(imem_rdata),
    .i_pop       (w_pop),
    .o_cnt       (w_q_cnt),
    .o_head      (w_head)
  );

  // PC advances on accept; redirect loads the aligned target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_acc) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Outstanding and to-be-discarded response counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + CW'(w_acc) - CW'(w_rv);
      if (redirect_valid) begin
        r_drop_cnt <= r_out_cnt - CW'(w_rv);
      end else if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // IF/ID register: redirect flush, stall hold, pop or bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id <= if_id_bubble();
      r_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        redirect_valid: begin
          r_if_id <= if_id_bubble();
          r_valid <= 1'b0;
        end
        stall: begin
          r_if_id <= r_if_id;
          r_valid <= r_valid;
        end
        w_pop: begin
          r_if_id <= '{instr: w_head.instr,
                       pc: w_head.pc};
          r_valid <= 1'b1;
        end
        default: begin
          r_if_id <= if_id_bubble();
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  a_q_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, w_q_cnt} <= LIM);
  a_out_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, r_out_cnt} <= LIM);
  a_rv_proto: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (r_out_cnt != '0));

endmodule
